// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the tristate bus arbiter: state encoding, default
// parameter values and a width helper.
package tristate_bus_pkg;

    localparam int N_SRC_DEF    = 2;
    localparam int W_DEF        = 1;
    localparam int TURN_CYC_DEF = 1;
    localparam int MAX_HOLD_DEF = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    // Counter/index widths never collapse to zero bits, even for a range of 1.
    function automatic int min1_clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/data/grant/capture bundle between bus sources and the arbiter.
// The tristate bus itself stays a plain inout net on the arbiter.
interface tristate_bus_arbiter_if
    import tristate_bus_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int W     = W_DEF
);

    logic [N_SRC-1:0]   req;
    logic [N_SRC*W-1:0] din;
    logic [N_SRC-1:0]   gnt;
    logic               busy;
    logic               vld;
    logic [W-1:0]       dout;

    modport master (output req, din, input gnt, busy, vld, dout);
    modport slave  (input req, din, output gnt, busy, vld, dout);

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot select of the first request at
// or after ptr, wrapping to the lowest index otherwise.
module rr_pick
    import tristate_bus_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int PTR_W = min1_clog2(N_SRC_DEF)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_SRC-1:0] sel,
    output logic             any
);

    logic [N_SRC-1:0] sel_hi;
    logic [N_SRC-1:0] sel_lo;
    logic             hit_hi;
    logic             hit_lo;

    // Two scans: requests at/above ptr win; the plain lowest request is the wrap fallback.
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i] && (i >= int'(ptr)) && !hit_hi) begin
                sel_hi[i] = 1'b1;
                hit_hi    = 1'b1;
            end
            if (req[i] && !hit_lo) begin
                sel_lo[i] = 1'b1;
                hit_lo    = 1'b1;
            end
        end
        sel = hit_hi ? sel_hi : sel_lo;
    end

    assign any = |req;

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with turnaround dead cycles,
// a hold limit per grant, and capture of the driven word.
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N_SRC    = N_SRC_DEF,
    parameter int W        = W_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire  [W-1:0]         bus,
    tristate_bus_arbiter_if.slave bif
);

    localparam int PTR_W  = min1_clog2(N_SRC);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = min1_clog2(TURN_CYC);

    logic [1:0]        state;
    logic [N_SRC-1:0]  gnt;
    logic [N_SRC-1:0]  sel;
    logic              any;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  gidx;
    logic [PTR_W-1:0]  ptr_next;
    logic [HOLD_W-1:0] hold;
    logic [TURN_W-1:0] turn;
    logic              vld;
    logic [W-1:0]      dout;
    logic              req_own;

    rr_pick #(
        .N_SRC (N_SRC),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (bif.req),
        .ptr (ptr),
        .sel (sel),
        .any (any)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) gidx = PTR_W'(i);
        end
    end

    assign ptr_next = (gidx == PTR_W'(N_SRC - 1)) ? '0 : gidx + 1'b1;
    assign req_own  = |(bif.req & gnt);

    // The per-source drivers are mutually exclusive, so they collapse into one enable.
    assign bus = (|gnt) ? bif.din[int'(gidx)*W +: W] : {W{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            hold  <= '0;
            turn  <= '0;
            vld   <= 1'b0;
            dout  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vld <= 1'b0;
                    if (any) begin
                        gnt   <= sel;
                        hold  <= HOLD_W'(1);
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    vld  <= 1'b1;
                    dout <= bus;
                    if (req_own && (hold < HOLD_W'(MAX_HOLD))) begin
                        hold <= hold + 1'b1;
                    end else begin
                        gnt   <= '0;
                        ptr   <= ptr_next;
                        turn  <= TURN_W'(TURN_CYC - 1);
                        state <= TURN;
                    end
                end
                TURN: begin
                    vld <= 1'b0;
                    if (turn == '0) state <= IDLE;
                    else            turn  <= turn - 1'b1;
                end
                default: begin
                    vld   <= 1'b0;
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bif.gnt  = gnt;
    assign bif.busy = (state != IDLE);
    assign bif.vld  = vld;
    assign bif.dout = dout;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N_SRC=2, W=1, TURN_CYC=1, MAX_HOLD=4)
// with hand-computed expectations and a per-cycle contention monitor.
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst;
    wire  [0:0] bus;
    int         n_compared;
    int         n_mismatched;
    logic [1:0] prev_gnt;

    logic [1:0] rr_both [13] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    logic [1:0] rr_solo [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                                 2'b01, 2'b01, 2'b01, 2'b01};

    tristate_bus_arbiter_if #(.N_SRC(2), .W(1)) bif ();

    tristate_bus_arbiter #(
        .N_SRC    (2),
        .W        (1),
        .TURN_CYC (1),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .bif (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] din);
        bif.req = req;
        bif.din = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across an edge, then releases it mid-cycle with stimulus already applied.
    task automatic applyReset(input logic [1:0] req, input logic [1:0] din);
        rst = 1'b1;
        applyStimulus(req, din);
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("onehot0", 32'($onehot0(bif.gnt)), 32'd1);
            if (bif.gnt != 2'b00)
                checkOutput("bus_known", 32'($isunknown(bus)), 32'd0);
        end
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        applyStimulus(2'b11, 2'b00);
        #2;
        checkOutput("rst_gnt",  32'(bif.gnt),  32'd0);
        checkOutput("rst_vld",  32'(bif.vld),  32'd0);
        checkOutput("rst_dout", 32'(bif.dout), 32'd0);
        checkOutput("rst_busy", 32'(bif.busy), 32'd0);
        tick();
        checkOutput("rst_gnt_edge", 32'(bif.gnt), 32'd0);

        $display("[TB] single source");
        applyReset(2'b01, 2'b01);
        tick();
        checkOutput("single_gnt",  32'(bif.gnt),  32'd1);
        checkOutput("single_bus",  32'(bus),      32'd1);
        checkOutput("single_busy", 32'(bif.busy), 32'd1);
        checkOutput("single_vld0", 32'(bif.vld),  32'd0);
        tick();
        checkOutput("single_vld",  32'(bif.vld),  32'd1);
        checkOutput("single_dout", 32'(bif.dout), 32'd1);

        $display("[TB] handover");
        applyReset(2'b11, 2'b10);
        tick();
        checkOutput("ho_gnt0", 32'(bif.gnt), 32'd1);
        checkOutput("ho_bus0", 32'(bus),     32'd0);
        applyStimulus(2'b10, 2'b10);
        tick();
        checkOutput("ho_turn_gnt",  32'(bif.gnt),  32'd0);
        checkOutput("ho_turn_busy", 32'(bif.busy), 32'd1);
        checkOutput("ho_turn_vld",  32'(bif.vld),  32'd1);
        checkOutput("ho_turn_dout", 32'(bif.dout), 32'd0);
        tick();
        checkOutput("ho_idle_gnt",  32'(bif.gnt),  32'd0);
        checkOutput("ho_idle_busy", 32'(bif.busy), 32'd0);
        checkOutput("ho_idle_vld",  32'(bif.vld),  32'd0);
        tick();
        checkOutput("ho_gnt1", 32'(bif.gnt), 32'd2);
        checkOutput("ho_bus1", 32'(bus),     32'd1);
        tick();
        checkOutput("ho_vld1",  32'(bif.vld),  32'd1);
        checkOutput("ho_dout1", 32'(bif.dout), 32'd1);

        $display("[TB] fairness, both requesting");
        applyReset(2'b11, 2'b01);
        prev_gnt = 2'b00;
        for (int k = 0; k < 13; k++) begin
            tick();
            checkOutput("rr_gnt", 32'(bif.gnt), 32'(rr_both[k]));
            checkOutput("rr_vld", 32'(bif.vld), 32'(prev_gnt != 2'b00));
            if (rr_both[k] == 2'b01)      checkOutput("rr_bus", 32'(bus), 32'd1);
            else if (rr_both[k] == 2'b10) checkOutput("rr_bus", 32'(bus), 32'd0);
            prev_gnt = rr_both[k];
        end

        $display("[TB] fairness, single requester");
        applyReset(2'b01, 2'b01);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("solo_gnt", 32'(bif.gnt), 32'(rr_solo[k]));
        end

        $display("[TB] async reset mid-drive");
        applyReset(2'b10, 2'b10);
        tick();
        checkOutput("ar_gnt_a", 32'(bif.gnt), 32'd2);
        tick();
        checkOutput("ar_gnt_b", 32'(bif.gnt),  32'd2);
        checkOutput("ar_dout",  32'(bif.dout), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_gnt_now",  32'(bif.gnt),  32'd0);
        checkOutput("ar_busy_now", 32'(bif.busy), 32'd0);
        checkOutput("ar_vld_now",  32'(bif.vld),  32'd0);
        checkOutput("ar_dout_now", 32'(bif.dout), 32'd0);
        tick();
        checkOutput("ar_vld_edge", 32'(bif.vld), 32'd0);
        checkOutput("ar_gnt_edge", 32'(bif.gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("ar_regrant", 32'(bif.gnt), 32'd2);
        checkOutput("ar_vld_rg",  32'(bif.vld), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
